// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/BLINK_INV modes with a
// shared blink prescaler and shared PWM counter so equal settings stay phase-locked.
module led_blink_multi #(
  parameter int unsigned g_CHANNELS   = 4,
  parameter int unsigned g_COUNT_TICK = 25000,
  parameter int unsigned g_PWM_BITS   = 4
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic [2*g_CHANNELS-1:0]          i_Mode,
  input  logic [8*g_CHANNELS-1:0]          i_Half,
  input  logic [g_PWM_BITS*g_CHANNELS-1:0] i_Duty,
  output logic [g_CHANNELS-1:0]            o_LED
);

  localparam int unsigned PRE_W = (g_COUNT_TICK > 2) ? $clog2(g_COUNT_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(g_COUNT_TICK - 1);
  localparam logic [g_PWM_BITS-1:0] DUTY_FULL = {g_PWM_BITS{1'b1}};

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_ON        = 2'b01,
    MODE_BLINK     = 2'b10,
    MODE_BLINK_INV = 2'b11
  } mode_e;

  logic [PRE_W-1:0]      pre_cnt;
  logic [PRE_W-1:0]      pre_cnt_nxt;
  logic                  tick_c;
  logic [g_PWM_BITS-1:0] pwm_cnt;

  logic [7:0]            blink_cnt     [g_CHANNELS];
  logic [7:0]            blink_cnt_nxt [g_CHANNELS];
  logic [g_CHANNELS-1:0] phase;
  logic [g_CHANNELS-1:0] phase_nxt;
  logic [g_CHANNELS-1:0] led_nxt;

  mode_e                 mode_c    [g_CHANNELS];
  logic [7:0]            half_m1_c [g_CHANNELS];
  logic [g_CHANNELS-1:0] pwm_on_c;

  // Per-channel field extraction; a half-period of 0 behaves like 1.
  for (genvar n = 0; n < g_CHANNELS; n++) begin : g_dec
    logic [7:0]            half;
    logic [g_PWM_BITS-1:0] duty;
    assign half         = i_Half[8*n +: 8];
    assign duty         = i_Duty[g_PWM_BITS*n +: g_PWM_BITS];
    assign mode_c[n]    = mode_e'(i_Mode[2*n +: 2]);
    assign half_m1_c[n] = (half == 8'd0) ? 8'd0 : half - 8'd1;
    assign pwm_on_c[n]  = (duty == DUTY_FULL) || (pwm_cnt < duty);
  end

  always_comb begin
    tick_c      = (pre_cnt == PRE_LAST);
    pre_cnt_nxt = tick_c ? '0 : pre_cnt + PRE_W'(1);
  end

  // Blink state advance and next LED drive, evaluated against current state.
  always_comb begin
    phase_nxt = phase;
    led_nxt   = '0;
    for (int unsigned n = 0; n < g_CHANNELS; n++) begin
      blink_cnt_nxt[n] = blink_cnt[n];
      unique case (mode_c[n])
        MODE_OFF:       led_nxt[n] = 1'b0;
        MODE_ON:        led_nxt[n] = pwm_on_c[n];
        MODE_BLINK:     led_nxt[n] = phase[n] & pwm_on_c[n];
        MODE_BLINK_INV: led_nxt[n] = ~phase[n] & pwm_on_c[n];
        default:        led_nxt[n] = 1'b0;
      endcase
      if ((mode_c[n] == MODE_OFF) || (mode_c[n] == MODE_ON)) begin
        blink_cnt_nxt[n] = 8'd0;
        phase_nxt[n]     = 1'b0;
      end else if (tick_c) begin
        // >= rather than == so a shrunk half-period toggles instead of wrapping.
        if (blink_cnt[n] >= half_m1_c[n]) begin
          blink_cnt_nxt[n] = 8'd0;
          phase_nxt[n]     = ~phase[n];
        end else begin
          blink_cnt_nxt[n] = blink_cnt[n] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      phase   <= '0;
      o_LED   <= '0;
      for (int unsigned n = 0; n < g_CHANNELS; n++) begin
        blink_cnt[n] <= 8'd0;
      end
    end else begin
      pre_cnt <= pre_cnt_nxt;
      pwm_cnt <= pwm_cnt + g_PWM_BITS'(1);
      phase   <= phase_nxt;
      o_LED   <= led_nxt;
      for (int unsigned n = 0; n < g_CHANNELS; n++) begin
        blink_cnt[n] <= blink_cnt_nxt[n];
      end
    end
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// Randomised bench for led_blink_multi: a cycle-count based reference model is
// compared every cycle, and directed scenarios pin the waveform with literals.
module tb_led_blink_multi;

  localparam int unsigned CH   = 2;
  localparam int unsigned TICK = 5;
  localparam int unsigned PB   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2*CH-1:0]   mode_v = '0;
  logic [8*CH-1:0]   half_v = '0;
  logic [PB*CH-1:0]  duty_v = '0;
  logic [CH-1:0]     led;

  int errors = 0;
  int checks = 0;
  int kcur   = 0;

  led_blink_multi #(
    .g_CHANNELS  (CH),
    .g_COUNT_TICK(TICK),
    .g_PWM_BITS  (PB)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .i_Mode(mode_v),
    .i_Half(half_v),
    .i_Duty(duty_v),
    .o_LED (led)
  );

  always #1 clk = ~clk;

  // Reference model: time is "cycles since reset", tick and PWM follow from it.
  int          t = 0;
  int          m_cnt [CH];
  bit          m_ph  [CH];
  logic [CH-1:0] exp_led = '0;
  bit          mvalid = 0;
  bit          m_tick;
  int          m_pwm, m_mode, m_half, m_duty;
  bit          m_lit;

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      for (int n = 0; n < CH; n++) begin
        m_cnt[n] = 0;
        m_ph[n]  = 0;
      end
      exp_led = '0;
      mvalid  = 1;
    end else begin
      m_tick = ((t % TICK) == TICK - 1);
      m_pwm  = t % (1 << PB);
      for (int n = 0; n < CH; n++) begin
        m_mode = int'(mode_v[2*n +: 2]);
        m_half = int'(half_v[8*n +: 8]);
        m_duty = int'(duty_v[PB*n +: PB]);
        m_lit  = (m_duty == (1 << PB) - 1) || (m_pwm < m_duty);
        case (m_mode)
          0: exp_led[n] = 1'b0;
          1: exp_led[n] = m_lit;
          2: exp_led[n] = m_ph[n] && m_lit;
          default: exp_led[n] = !m_ph[n] && m_lit;
        endcase
        if (m_mode < 2) begin
          m_cnt[n] = 0;
          m_ph[n]  = 0;
        end else if (m_tick) begin
          if (m_half == 0) m_half = 1;
          if (m_cnt[n] >= m_half - 1) begin
            m_cnt[n] = 0;
            m_ph[n]  = !m_ph[n];
          end else begin
            m_cnt[n] = m_cnt[n] + 1;
          end
        end
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL model t=%0d: o_LED=%b expected=%b", t, led, exp_led);
      end
    end
  end

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic set_ch(input int n, input logic [1:0] m, input logic [7:0] h, input logic [PB-1:0] d);
    mode_v[2*n +: 2]   = m;
    half_v[8*n +: 8]   = h;
    duty_v[PB*n +: PB] = d;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst  = 1'b0;
    kcur = 0;
  endtask

  task automatic run_to(input int k);
    repeat (k - kcur) @(negedge clk);
    kcur = k;
  endtask

  int highs;

  initial begin
    @(negedge clk);

    // Steady ON at full duty, including the reset window.
    set_ch(0, 2'b01, 8'd0, 2'd3);
    set_ch(1, 2'b01, 8'd0, 2'd3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("on_during_reset", led, 2'b00);
    rst = 1'b0; kcur = 0;
    run_to(1);  check("on_first_edge", led, 2'b11);
    run_to(20); check("on_steady", led, 2'b11);

    // Blink half=2: rise at edge 11, 10 high / 10 low.
    set_ch(0, 2'b10, 8'd2, 2'd3);
    set_ch(1, 2'b00, 8'd0, 2'd0);
    do_reset(2);
    run_to(10); check("blink_pre_rise", led, 2'b00);
    run_to(11); check("blink_rise", led, 2'b01);
    run_to(20); check("blink_high_end", led, 2'b01);
    run_to(21); check("blink_fall", led, 2'b00);
    run_to(30); check("blink_low_end", led, 2'b00);
    run_to(31); check("blink_rise2", led, 2'b01);

    // PWM duty 1: high on 1 of 4 cycles; duty 0: never.
    set_ch(0, 2'b01, 8'd0, 2'd1);
    do_reset(1);
    highs = 0;
    for (int k = 1; k <= 40; k++) begin
      run_to(k);
      if (k == 1) check("pwm1_first", led, 2'b01);
      if (k == 2) check("pwm1_second", led, 2'b00);
      highs += int'(led[0]);
    end
    check_int("pwm1_high_count", highs, 10);
    set_ch(0, 2'b01, 8'd0, 2'd0);
    highs = 0;
    for (int k = 41; k <= 80; k++) begin
      run_to(k);
      highs += int'(led[0]);
    end
    check_int("pwm0_high_count", highs, 0);

    // BLINK vs BLINK_INV, half=1 then half=0: identical complementary waveform.
    for (int h = 1; h >= 0; h--) begin
      set_ch(0, 2'b10, 8'(h), 2'd3);
      set_ch(1, 2'b11, 8'(h), 2'd3);
      do_reset(1);
      run_to(5);  check("inv_k5", led, 2'b10);
      run_to(6);  check("inv_k6", led, 2'b01);
      run_to(10); check("inv_k10", led, 2'b01);
      run_to(11); check("inv_k11", led, 2'b10);
    end

    // Reset while lit, then restart from phase 0 with a fresh prescaler.
    set_ch(0, 2'b10, 8'd2, 2'd3);
    set_ch(1, 2'b00, 8'd0, 2'd0);
    do_reset(1);
    run_to(15); check("rst_mid_high", led, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_dark", led, 2'b00);
    rst = 1'b0; kcur = 0;
    run_to(10); check("rst_restart_dark", led, 2'b00);
    run_to(11); check("rst_restart_rise", led, 2'b01);

    // Half 4 -> 2 at count 3: toggle on the next tick, then 10-cycle halves.
    set_ch(0, 2'b10, 8'd4, 2'd3);
    do_reset(1);
    run_to(15); set_ch(0, 2'b10, 8'd2, 2'd3);
    run_to(20); check("shrink3_pre", led, 2'b00);
    run_to(21); check("shrink3_rise", led, 2'b01);
    run_to(30); check("shrink3_high", led, 2'b01);
    run_to(31); check("shrink3_fall", led, 2'b00);

    // Half 4 -> 2 at count 2 (new half <= count): toggle at the next tick, no wrap.
    set_ch(0, 2'b10, 8'd4, 2'd3);
    do_reset(1);
    run_to(10); set_ch(0, 2'b10, 8'd2, 2'd3);
    run_to(15); check("shrink2_pre", led, 2'b00);
    run_to(16); check("shrink2_rise", led, 2'b01);
    run_to(25); check("shrink2_high", led, 2'b01);
    run_to(26); check("shrink2_fall", led, 2'b00);

    // Random settings, mode changes and occasional resets against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        set_ch(int'($urandom_range(0, CH - 1)),
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3)),
               PB'($urandom_range(0, (1 << PB) - 1)));
      end
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
